// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared types and constants for the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_array
// Description : DEPTH x W word storage, synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    input  logic         i_rclr,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Wait-state data memory responder (LW/SW), one request at a
//               time. Optional misaligned-access error: MEM_RESPONDER_MISALIGN_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int c_IDX_W  = ADDR_W - BYTE_OFF_W;
    localparam int c_MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        c_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_err;

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [WORD_W-1:0]   w_acc_wdata;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_oor;
    logic                w_misalign;
    logic                w_fault;

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    // With zero wait states the access happens on the accept edge itself,
    // before the latched copy exists, so take the request inputs directly.
    assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_idx = w_acc_addr[ADDR_W-1:BYTE_OFF_W];
    assign w_oor = (32'(w_idx) >= 32'(DEPTH));

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    assign w_misalign = (w_acc_addr[BYTE_OFF_W-1:0] != '0);
`else
    logic w_unused_lo;
    assign w_misalign  = 1'b0;
    assign w_unused_lo = ^w_acc_addr[BYTE_OFF_W-1:0];
`endif

    assign w_fault = w_oor | w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) w_next = WAIT;
                    else                 w_next = RESP;
                end
            end
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        resp_valid = (r_state == RESP);
        resp_err   = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_err <= w_enter_resp & w_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    mem_responder_array #(
        .DEPTH (DEPTH),
        .AW    (c_MEM_AW),
        .W     (WORD_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_enter_resp &  w_acc_we & ~w_fault),
        .i_waddr (w_idx[c_MEM_AW-1:0]),
        .i_wdata (w_acc_wdata),
        .i_re    (w_enter_resp & ~w_acc_we & ~w_fault),
        .i_rclr  (w_enter_resp & ~w_acc_we &  w_fault),
        .i_raddr (w_idx[c_MEM_AW-1:0]),
        .o_rdata (resp_rdata)
    );

endmodule
`default_nettype wire
